// File: rtl/mbp_ctrl_pkg.sv
// Shared definitions for the registered ID-stage control unit:
// opcode/funct encodings, ALU/BCU operation codes, the ID/EX control
// word layout and the control FSM state type.
package mbp_ctrl_pkg;

    localparam int ALU_W = 5;
    localparam int BCU_W = 4;

    // Primary opcodes (instruction [31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes (instruction [5:0])
    localparam logic [5:0] F_SLL      = 6'h00;
    localparam logic [5:0] F_SRA      = 6'h03;
    localparam logic [5:0] F_JR       = 6'h08;
    localparam logic [5:0] F_SYSCALL  = 6'h0C;
    localparam logic [5:0] F_MFHI     = 6'h10;
    localparam logic [5:0] F_MFLO     = 6'h12;
    localparam logic [5:0] F_MULT     = 6'h18;
    localparam logic [5:0] F_MULTU    = 6'h19;
    localparam logic [5:0] F_DIV      = 6'h1A;
    localparam logic [5:0] F_DIVU     = 6'h1B;
    localparam logic [5:0] F_ADD      = 6'h20;
    localparam logic [5:0] F_ADDU     = 6'h21;
    localparam logic [5:0] F_SUB      = 6'h22;
    localparam logic [5:0] F_SUBU     = 6'h23;
    localparam logic [5:0] F_AND      = 6'h24;
    localparam logic [5:0] F_OR       = 6'h25;
    localparam logic [5:0] F_SLT      = 6'h2A;

    // ALU operations; zero is a harmless no-op so a cleared word is safe
    localparam logic [ALU_W-1:0] ALU_NOP = 5'd0;
    localparam logic [ALU_W-1:0] ALU_ADD = 5'd1;
    localparam logic [ALU_W-1:0] ALU_SUB = 5'd2;
    localparam logic [ALU_W-1:0] ALU_AND = 5'd3;
    localparam logic [ALU_W-1:0] ALU_OR  = 5'd4;
    localparam logic [ALU_W-1:0] ALU_SLT = 5'd5;
    localparam logic [ALU_W-1:0] ALU_SLL = 5'd6;
    localparam logic [ALU_W-1:0] ALU_SRA = 5'd7;

    // Branch comparison unit operations
    localparam logic [BCU_W-1:0] BCU_NONE = 4'd0;
    localparam logic [BCU_W-1:0] BCU_EQ   = 4'd1;
    localparam logic [BCU_W-1:0] BCU_NE   = 4'd2;
    localparam logic [BCU_W-1:0] BCU_LEZ  = 4'd3;
    localparam logic [BCU_W-1:0] BCU_GTZ  = 4'd4;

    // Jump kinds
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JR   = 2'b10;

    typedef struct packed {
        logic             load_upper;
        logic             jal;
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             alu_src;
        logic             reg_dst;
        logic             branch;
        logic             syscall;
        logic [1:0]       jump;
        logic [ALU_W-1:0] alu_control;
        logic [BCU_W-1:0] bcu_control;
    } ctrl_word_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MULDIV    = 2'd1,
        ST_SYS_DRAIN = 2'd2,
        ST_SYS_WAIT  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational op/funct decoder producing the ID/EX control word
// plus classification flags used by the pipeline control FSM.
// Unrecognised encodings yield an all-zero word with o_is_illegal set.
module ctrl_decode
    import mbp_ctrl_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    output ctrl_word_t  o_word,
    output logic        o_is_muldiv,
    output logic        o_is_hilo,
    output logic        o_is_syscall,
    output logic        o_is_illegal
);

    // Table decode of the supported subset
    always_comb begin
        o_word       = '0;
        o_is_muldiv  = 1'b0;
        o_is_hilo    = 1'b0;
        o_is_syscall = 1'b0;
        o_is_illegal = 1'b0;
        case (i_op)
            OP_SPECIAL: begin
                case (i_funct)
                    F_ADD, F_ADDU: begin
                        o_word.reg_write   = 1'b1;
                        o_word.reg_dst     = 1'b1;
                        o_word.alu_control = ALU_ADD;
                    end
                    F_SUB, F_SUBU: begin
                        o_word.reg_write   = 1'b1;
                        o_word.reg_dst     = 1'b1;
                        o_word.alu_control = ALU_SUB;
                    end
                    F_AND: begin
                        o_word.reg_write   = 1'b1;
                        o_word.reg_dst     = 1'b1;
                        o_word.alu_control = ALU_AND;
                    end
                    F_OR: begin
                        o_word.reg_write   = 1'b1;
                        o_word.reg_dst     = 1'b1;
                        o_word.alu_control = ALU_OR;
                    end
                    F_SLT: begin
                        o_word.reg_write   = 1'b1;
                        o_word.reg_dst     = 1'b1;
                        o_word.alu_control = ALU_SLT;
                    end
                    F_SLL: begin
                        o_word.reg_write   = 1'b1;
                        o_word.reg_dst     = 1'b1;
                        o_word.alu_control = ALU_SLL;
                    end
                    F_SRA: begin
                        o_word.reg_write   = 1'b1;
                        o_word.reg_dst     = 1'b1;
                        o_word.alu_control = ALU_SRA;
                    end
                    F_JR:      o_word.jump = JUMP_JR;
                    F_SYSCALL: begin
                        o_word.syscall = 1'b1;
                        o_is_syscall   = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: o_is_muldiv = 1'b1;
                    F_MFHI, F_MFLO: begin
                        // Result comes from HI/LO, the ALU is bypassed
                        o_word.reg_write = 1'b1;
                        o_word.reg_dst   = 1'b1;
                        o_is_hilo        = 1'b1;
                    end
                    default:   o_is_illegal = 1'b1;
                endcase
            end
            OP_J:    o_word.jump = JUMP_J;
            OP_JAL: begin
                o_word.jump        = JUMP_J;
                o_word.jal         = 1'b1;
                o_word.reg_write   = 1'b1;
                o_word.alu_control = ALU_ADD;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                o_word.branch      = 1'b1;
                o_word.alu_control = ALU_SUB;
                case (i_op)
                    OP_BEQ:  o_word.bcu_control = BCU_EQ;
                    OP_BNE:  o_word.bcu_control = BCU_NE;
                    OP_BLEZ: o_word.bcu_control = BCU_LEZ;
                    default: o_word.bcu_control = BCU_GTZ;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                o_word.reg_write   = 1'b1;
                o_word.alu_src     = 1'b1;
                o_word.alu_control = ALU_ADD;
            end
            OP_ANDI: begin
                o_word.reg_write   = 1'b1;
                o_word.alu_src     = 1'b1;
                o_word.alu_control = ALU_AND;
            end
            OP_ORI: begin
                o_word.reg_write   = 1'b1;
                o_word.alu_src     = 1'b1;
                o_word.alu_control = ALU_OR;
            end
            OP_LUI: begin
                o_word.load_upper  = 1'b1;
                o_word.reg_write   = 1'b1;
                o_word.alu_src     = 1'b1;
                o_word.alu_control = ALU_ADD;
            end
            OP_LW: begin
                o_word.reg_write   = 1'b1;
                o_word.mem_to_reg  = 1'b1;
                o_word.alu_src     = 1'b1;
                o_word.alu_control = ALU_ADD;
            end
            OP_SW: begin
                o_word.mem_write   = 1'b1;
                o_word.alu_src     = 1'b1;
                o_word.alu_control = ALU_ADD;
            end
            default: o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered ID-stage control unit: decodes the IF/ID instruction into the
// ID/EX control word, handles stall/flush, tracks multi-cycle MULT/DIV
// occupancy of HI/LO and sequences the SYSCALL drain/handshake.
// Build option ILLEGAL_TRAP_EN: unrecognised encodings emit a bubble and
// pulse illegal_op; otherwise they pass through as a valid NOP.
module pipelined_control_unit
    import mbp_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W   = 5,
    parameter int BCU_CTRL_W   = 4,
    parameter int MULDIV_LAT   = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [5:0]            op_code,
    input  logic [5:0]            funct_code,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  syscall_ack,
    output logic                  out_valid,
    output logic                  load_upper,
    output logic                  jal,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  mem_write,
    output logic                  alu_src,
    output logic                  reg_dst,
    output logic                  branch,
    output logic                  syscall,
    output logic [1:0]            jump,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [BCU_CTRL_W-1:0] bcu_control,
    output logic                  muldiv_busy,
    output logic                  hold_req,
    output logic                  syscall_go
`ifdef ILLEGAL_TRAP_EN
    ,output logic                 illegal_op
`endif
);

    localparam int CNT_W = 6;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    ctrl_word_t  w_dec_word;
    logic        w_is_muldiv;
    logic        w_is_hilo;
    logic        w_is_syscall;
    logic        w_is_illegal;
    logic        w_md_pending;
    logic        w_hold;
    logic        w_accept;
    logic        w_launch_md;
    logic        w_launch_sys;
    ctrl_state_e w_next_state;
    logic [CNT_W-1:0] w_next_cnt;

    ctrl_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    ctrl_word_t       r_word;

    ctrl_decode u_decode (
        .i_op         (op_code),
        .i_funct      (funct_code),
        .o_word       (w_dec_word),
        .o_is_muldiv  (w_is_muldiv),
        .o_is_hilo    (w_is_hilo),
        .o_is_syscall (w_is_syscall),
        .o_is_illegal (w_is_illegal)
    );

    // HI/LO is still being produced except in the final busy cycle, where a
    // dependent op may be accepted so it reaches EX just as busy drops.
    assign w_md_pending = (r_state == ST_MULDIV) && (r_cnt != '0);

    assign w_hold = (r_state == ST_SYS_DRAIN) || (r_state == ST_SYS_WAIT) ||
                    (w_md_pending && in_valid && (w_is_muldiv || w_is_hilo || w_is_syscall));

    assign w_accept     = in_valid && !stall && !flush && !w_hold;
    assign w_launch_md  = w_accept && w_is_muldiv;
    assign w_launch_sys = w_accept && w_is_syscall;

    // Next-state and counter logic for the MULDIV / SYSCALL sequencer
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_launch_md) begin
                    w_next_state = ST_MULDIV;
                    w_next_cnt   = CNT_W'(MULDIV_LAT - 1);
                end else if (w_launch_sys) begin
                    w_next_state = ST_SYS_DRAIN;
                    w_next_cnt   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_MULDIV: begin
                // flush cannot cancel an op that has already issued
                if (r_cnt != '0) begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end else if (w_launch_md) begin
                    w_next_cnt = CNT_W'(MULDIV_LAT - 1);
                end else if (w_launch_sys) begin
                    w_next_state = ST_SYS_DRAIN;
                    w_next_cnt   = CNT_W'(DRAIN_CYCLES - 1);
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SYS_DRAIN: begin
                if (flush) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == '0) begin
                    w_next_state = ST_SYS_WAIT;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_SYS_WAIT: begin
                if (syscall_ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // ID/EX control word: flush clears, stall holds, otherwise load or bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (!stall) begin
            r_valid <= w_accept && !(TRAP_EN && w_is_illegal);
            r_word  <= w_accept ? w_dec_word : '0;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    // One-cycle pulse for each accepted unrecognised encoding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && w_is_illegal;
        end
    end

    assign illegal_op = r_illegal;
`endif

    assign out_valid   = r_valid;
    assign load_upper  = r_word.load_upper;
    assign jal         = r_word.jal;
    assign reg_write   = r_word.reg_write;
    assign mem_to_reg  = r_word.mem_to_reg;
    assign mem_write   = r_word.mem_write;
    assign alu_src     = r_word.alu_src;
    assign reg_dst     = r_word.reg_dst;
    assign branch      = r_word.branch;
    assign syscall     = r_word.syscall;
    assign jump        = r_word.jump;
    assign alu_control = ALU_CTRL_W'(r_word.alu_control);
    assign bcu_control = BCU_CTRL_W'(r_word.bcu_control);
    assign muldiv_busy = (r_state == ST_MULDIV);
    assign hold_req    = w_hold;
    assign syscall_go  = (r_state == ST_SYS_WAIT);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit (MULDIV_LAT=4, DRAIN_CYCLES=3).
// Expected ID/EX words are queued when an instruction is driven and
// compared after the edge that should produce them.
// Honours ILLEGAL_TRAP_EN to match the DUT build.
module tb_pipelined_control_unit;
    import mbp_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] op_code;
    logic [5:0] funct_code;
    logic       stall;
    logic       flush;
    logic       syscall_ack;
    logic       out_valid, load_upper, jal, reg_write, mem_to_reg, mem_write;
    logic       alu_src, reg_dst, branch, syscall;
    logic [1:0] jump;
    logic [4:0] alu_control;
    logic [3:0] bcu_control;
    logic       muldiv_busy, hold_req, syscall_go;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [20:0] sb_q[$];
    string       sb_tag[$];
    logic [20:0] obs;

    logic [20:0] W_ADDIU, W_LW, W_SW, W_BEQ, W_JR, W_JAL, W_MULT, W_MFLO, W_SYS, W_NOP;

    always #5 clk = ~clk;

    pipelined_control_unit #(
        .ALU_CTRL_W   (5),
        .BCU_CTRL_W   (4),
        .MULDIV_LAT   (4),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .op_code     (op_code),
        .funct_code  (funct_code),
        .stall       (stall),
        .flush       (flush),
        .syscall_ack (syscall_ack),
        .out_valid   (out_valid),
        .load_upper  (load_upper),
        .jal         (jal),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .mem_write   (mem_write),
        .alu_src     (alu_src),
        .reg_dst     (reg_dst),
        .branch      (branch),
        .syscall     (syscall),
        .jump        (jump),
        .alu_control (alu_control),
        .bcu_control (bcu_control),
        .muldiv_busy (muldiv_busy),
        .hold_req    (hold_req),
        .syscall_go  (syscall_go)
`ifdef ILLEGAL_TRAP_EN
        ,.illegal_op (illegal_op)
`endif
    );

    assign obs = {out_valid, load_upper, jal, reg_write, mem_to_reg, mem_write,
                  alu_src, reg_dst, branch, syscall, jump, alu_control, bcu_control};

    function automatic logic [20:0] mk(input logic v, input logic lu, input logic jl,
                                       input logic rw, input logic mtr, input logic mw,
                                       input logic as, input logic rd, input logic br,
                                       input logic sc, input logic [1:0] jmp,
                                       input logic [4:0] alu, input logic [3:0] bcu);
        return {v, lu, jl, rw, mtr, mw, as, rd, br, sc, jmp, alu, bcu};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [20:0] w, input string tag);
        sb_q.push_back(w);
        sb_tag.push_back(tag);
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
        in_valid   = v;
        op_code    = op;
        funct_code = fn;
    endtask

    // Advance one clock and compare the oldest queued word, if any
    task automatic tick();
        logic [20:0] e;
        string       t;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = sb_tag.pop_front();
            chk(t, 32'(obs), 32'(e));
        end
    endtask

    initial begin
        W_ADDIU = mk(1, 0,0,1,0,0,1,0,0,0, JUMP_NONE, ALU_ADD, BCU_NONE);
        W_LW    = mk(1, 0,0,1,1,0,1,0,0,0, JUMP_NONE, ALU_ADD, BCU_NONE);
        W_SW    = mk(1, 0,0,0,0,1,1,0,0,0, JUMP_NONE, ALU_ADD, BCU_NONE);
        W_BEQ   = mk(1, 0,0,0,0,0,0,0,1,0, JUMP_NONE, ALU_SUB, BCU_EQ);
        W_JR    = mk(1, 0,0,0,0,0,0,0,0,0, JUMP_JR,   ALU_NOP, BCU_NONE);
        W_JAL   = mk(1, 0,1,1,0,0,0,0,0,0, JUMP_J,    ALU_ADD, BCU_NONE);
        W_MULT  = mk(1, 0,0,0,0,0,0,0,0,0, JUMP_NONE, ALU_NOP, BCU_NONE);
        W_MFLO  = mk(1, 0,0,1,0,0,0,1,0,0, JUMP_NONE, ALU_NOP, BCU_NONE);
        W_SYS   = mk(1, 0,0,0,0,0,0,0,0,1, JUMP_NONE, ALU_NOP, BCU_NONE);
        W_NOP   = mk(1, 0,0,0,0,0,0,0,0,0, JUMP_NONE, ALU_NOP, BCU_NONE);

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; syscall_ack = 1'b0;
        drive(1'b0, 6'h00, 6'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_word", 32'(obs), 32'd0);
        chk("reset_busy", 32'(muldiv_busy), 32'd0);
        chk("reset_hold", 32'(hold_req), 32'd0);
        chk("reset_go",   32'(syscall_go), 32'd0);
`ifdef ILLEGAL_TRAP_EN
        chk("reset_illegal", 32'(illegal_op), 32'd0);
`endif
        rst_n = 1'b1;

        // ADDIU accepted, then squashed by flush, then a bubble
        drive(1'b1, OP_ADDIU, 6'h00); push(W_ADDIU, "addiu"); tick();
        flush = 1'b1; push(21'd0, "addiu_flush"); tick(); flush = 1'b0;
        drive(1'b0, OP_ADDIU, 6'h00); push(21'd0, "bubble"); tick();

        // A few more decode patterns
        drive(1'b1, OP_SW, 6'h00);         push(W_SW,  "sw");  tick();
        drive(1'b1, OP_BEQ, 6'h00);        push(W_BEQ, "beq"); tick();
        drive(1'b1, OP_SPECIAL, F_JR);     push(W_JR,  "jr");  tick();
        drive(1'b1, OP_JAL, 6'h00);        push(W_JAL, "jal"); tick();

        // LW held by a 3-cycle stall, then the next word loads
        drive(1'b1, OP_LW, 6'h00); push(W_LW, "lw"); tick();
        drive(1'b1, OP_ADDIU, 6'h00); stall = 1'b1;
        repeat (3) begin push(W_LW, "lw_stall"); tick(); end
        stall = 1'b0; push(W_ADDIU, "after_stall"); tick();

        // MULT then MFLO: busy for 4 cycles, MFLO lands as busy drops
        drive(1'b1, OP_SPECIAL, F_MULT); push(W_MULT, "mult"); tick();
        chk("mult_busy0", 32'(muldiv_busy), 32'd1);
        drive(1'b1, OP_SPECIAL, F_MFLO); #1;
        chk("mflo_hold0", 32'(hold_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            push(21'd0, "mflo_held"); tick();
            chk("mult_busy", 32'(muldiv_busy), 32'd1);
            chk("mflo_hold", 32'(hold_req), (i < 2) ? 32'd1 : 32'd0);
        end
        push(W_MFLO, "mflo"); tick();
        chk("mflo_busy_off", 32'(muldiv_busy), 32'd0);

        // Unrelated ops flow during MULDIV
        drive(1'b1, OP_SPECIAL, F_DIVU); push(W_MULT, "divu"); tick();
        drive(1'b1, OP_ADDIU, 6'h00); #1;
        chk("md_flow_hold", 32'(hold_req), 32'd0);
        push(W_ADDIU, "md_flow_addiu"); tick();
        drive(1'b0, OP_ADDIU, 6'h00);
        repeat (2) begin push(21'd0, "md_bubble"); tick(); end
        chk("divu_busy_last", 32'(muldiv_busy), 32'd1);
        push(21'd0, "md_bubble"); tick();
        chk("divu_busy_done", 32'(muldiv_busy), 32'd0);

        // SYSCALL: drain 3 cycles, wait for ack, flush ignored while waiting
        drive(1'b1, OP_SPECIAL, F_SYSCALL); push(W_SYS, "syscall"); tick();
        chk("drain_hold0", 32'(hold_req), 32'd1);
        drive(1'b1, OP_ADDIU, 6'h00);
        for (int i = 0; i < 3; i++) begin
            push(21'd0, "drain_bubble"); tick();
            chk("drain_go", 32'(syscall_go), (i == 2) ? 32'd1 : 32'd0);
            chk("drain_hold", 32'(hold_req), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            flush = (i == 1);
            push(21'd0, "wait_bubble"); tick();
            chk("wait_go", 32'(syscall_go), 32'd1);
            chk("wait_hold", 32'(hold_req), 32'd1);
        end
        flush = 1'b0; syscall_ack = 1'b1; drive(1'b0, OP_ADDIU, 6'h00);
        push(21'd0, "ack_bubble"); tick();
        chk("ack_go", 32'(syscall_go), 32'd0);
        chk("ack_hold", 32'(hold_req), 32'd0);
        syscall_ack = 1'b0;

        // SYSCALL squashed by flush during drain: go never rises
        drive(1'b1, OP_SPECIAL, F_SYSCALL); push(W_SYS, "syscall2"); tick();
        drive(1'b0, OP_ADDIU, 6'h00); flush = 1'b1;
        push(21'd0, "sys_flush"); tick(); flush = 1'b0;
        chk("sys_flush_hold", 32'(hold_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            syscall_ack = (i == 0);
            push(21'd0, "squash_bubble"); tick();
            chk("squash_go", 32'(syscall_go), 32'd0);
        end
        syscall_ack = 1'b0;
        drive(1'b1, OP_ADDIU, 6'h00); push(W_ADDIU, "post_squash"); tick();

        // Asynchronous reset in the middle of MULDIV
        drive(1'b1, OP_SPECIAL, F_MULT); push(W_MULT, "mult2"); tick();
        drive(1'b1, OP_ADDIU, 6'h00); push(W_ADDIU, "mult2_addiu"); tick();
        chk("pre_rst_busy", 32'(muldiv_busy), 32'd1);
        drive(1'b0, OP_ADDIU, 6'h00);
        rst_n = 1'b0; #1;
        chk("arst_word", 32'(obs), 32'd0);
        chk("arst_busy", 32'(muldiv_busy), 32'd0);
        chk("arst_hold", 32'(hold_req), 32'd0);
        #2 rst_n = 1'b1;
        chk("post_rst_busy", 32'(muldiv_busy), 32'd0);

        // Undefined opcode after reset
        drive(1'b1, 6'h3F, 6'h00);
`ifdef ILLEGAL_TRAP_EN
        push(21'd0, "illegal_bubble"); tick();
        chk("illegal_pulse", 32'(illegal_op), 32'd1);
        drive(1'b0, 6'h00, 6'h00);
        push(21'd0, "illegal_after"); tick();
        chk("illegal_clear", 32'(illegal_op), 32'd0);
`else
        push(W_NOP, "undef_nop"); tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
